pci_arbiter: RTL and testbench
==============================

PCI_ARBITER -- requirements
Module: pci_arbiter

Interface
REQ-001 Parameter: NUM_MASTERS, default 4, number of bus masters arbitrated (2..8).
REQ-002 Parameter: PARK_ID, default 0, master that holds GNT when no request is pending.
REQ-003 Parameter: GNT_TIMEOUT, default 16, idle clocks a granted master has to assert frame before its grant is revoked.
REQ-004 Port: clk  input  1  PCI bus clock; all logic is on its rising edge; one clock only.
REQ-005 Port: rst  input  1  reset, asynchronous, active-low.
REQ-006 Port: req  input  NUM_MASTERS  per-master REQ#, active-low.
REQ-007 Port: gnt  output  NUM_MASTERS  per-master GNT#, active-low, registered.
REQ-008 Port: frame  input  1  bus FRAME#, active-low, sampled only.
REQ-009 Port: irdy  input  1  bus IRDY#, active-low, sampled only.
REQ-010 Port: owner  output  $clog2(NUM_MASTERS)  index of the master currently granted or on the bus.
REQ-011 Port: owner_valid  output  1  high when owner is meaningful (state GRANT, BUSY or PARK).

Function
REQ-012 Bus idle SHALL be defined as frame==1 and irdy==1 in the same sampled cycle.
REQ-013 The FSM SHALL have states DEAD, PARK, GRANT and BUSY.
REQ-014 At most one gnt bit SHALL be low in any cycle.
REQ-015 Winner selection SHALL be round-robin over low req bits, starting at last_owner+1 and wrapping from NUM_MASTERS-1 to 0.
REQ-016 DEAD: all gnt high. Next state is GRANT to the winner if any req is low, else PARK.
REQ-017 PARK: gnt[PARK_ID] low.
  - req[PARK_ID] is the winner -> GRANT, with no gnt gap.
  - Any other winner -> DEAD.
  - frame low -> BUSY, owner=PARK_ID.
REQ-018 GRANT: gnt[owner] low; the timeout counter increments every idle cycle.
  - frame low -> BUSY; the counter clears.
  - Counter reaches GNT_TIMEOUT -> DEAD; the timed-out master becomes last_owner.
  - req[owner] high while the bus is idle -> DEAD.
REQ-019 BUSY: gnt[owner] stays low while no other req is low, and goes high from the cycle after any other req is sampled low.
REQ-020 BUSY exit on bus idle:
  - Same master wins and gnt[owner] is still low -> GRANT.
  - Otherwise -> DEAD.
  - last_owner updates to owner on exit.
REQ-021 Between deasserting one master's gnt and asserting another master's gnt there SHALL be at least one clock with all gnt high.
REQ-022 A req change SHALL affect gnt no earlier than the next rising edge (one-cycle latency).
REQ-023 req and frame low together in PARK or GRANT SHALL give BUSY priority over any re-arbitration.
REQ-024 The timeout counter SHALL saturate at GNT_TIMEOUT and never wrap.

Reset
REQ-025 While rst is low, the block SHALL hold:
  - gnt all high
  - state DEAD
  - counter 0
  - last_owner NUM_MASTERS-1
  - owner 0
  - owner_valid 0
REQ-026 Reset asserted mid-transaction SHALL release all gnt asynchronously; after rst rises, arbitration restarts from DEAD with master 0 first.

Structure
REQ-027 The FSM state enum and the GNT_TIMEOUT default SHALL live in shared package pci_pkg.
REQ-028 The round-robin winner search SHALL be a combinational sub-module pci_arb_rr (inputs: request vector, last_owner; outputs: winner, any).
REQ-029 All FSM, counter and gnt registers SHALL live in pci_arbiter.

Verification
REQ-030 After reset release, req=4'b1111 and bus idle -> one DEAD cycle, then gnt=4'b1110 (park on 0) with owner_valid=1.
REQ-031 Parked on 0, req=4'b1011 -> one cycle gnt=4'b1111, then gnt=4'b1011, owner=2.
REQ-032 req=4'b0000 held, each master runs a one-transaction frame -> grant order 0,1,2,3,0 with a dead cycle between each.
REQ-033 Master 1 granted and never asserts frame -> gnt[1] high after 16 idle cycles; master 2 (req low) granted after one dead cycle.
REQ-034 Master 3 is BUSY and req[0] goes low -> gnt[3] high the next cycle, master 3 keeps the bus until idle, then one DEAD cycle, then gnt=4'b1110.
REQ-035 rst pulsed low during BUSY -> gnt=4'b1111 immediately, with no clock edge needed; the scenario in REQ-030 repeats afterwards.

Source files
------------

// File: rtl/pci_pkg.sv
// Shared types and defaults for the PCI bus arbiter.
package pci_pkg;

  typedef enum logic [1:0] {
    DEAD  = 2'd0,
    PARK  = 2'd1,
    GRANT = 2'd2,
    BUSY  = 2'd3
  } arb_state_e;

  localparam int GNT_TIMEOUT_DEF = 16;

endpackage

// File: rtl/pci_arb_rr.sv
// Combinational round-robin search: first requester after last_owner, wrapping.
module pci_arb_rr #(
  parameter int NUM_MASTERS = 4,
  parameter int OW          = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [OW-1:0]          last_owner_i,
  output logic [OW-1:0]          winner_o,
  output logic                   any_o
);

  logic [OW-1:0] idx_s;
  logic          hit_s;

  // Scan farthest offset first so the nearest requester is the last one written.
  always_comb begin
    winner_o = '0;
    any_o    = 1'b0;
    idx_s    = '0;
    hit_s    = 1'b0;
    for (int off = NUM_MASTERS; off >= 1; off--) begin
      idx_s    = OW'((int'(last_owner_i) + off) % NUM_MASTERS);
      hit_s    = req_i[idx_s];
      winner_o = hit_s ? idx_s : winner_o;
      any_o    = any_o | hit_s;
    end
  end

endmodule

// File: rtl/pci_arbiter.sv
// PCI central arbiter: round-robin GNT# with parking, grant timeout and
// an all-high turnaround cycle between different owners.
module pci_arbiter
  import pci_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int PARK_ID     = 0,
  parameter int GNT_TIMEOUT = GNT_TIMEOUT_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_MASTERS-1:0]         req,
  output logic [NUM_MASTERS-1:0]         gnt,
  input  logic                           frame,
  input  logic                           irdy,
  output logic [$clog2(NUM_MASTERS)-1:0] owner,
  output logic                           owner_valid
);

  localparam int            OW       = $clog2(NUM_MASTERS);
  localparam int            CW       = $clog2(GNT_TIMEOUT + 1);
  localparam logic [OW-1:0] PARK_IDX = OW'(PARK_ID);
  localparam logic [OW-1:0] LAST_RST = OW'(NUM_MASTERS - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(GNT_TIMEOUT);

  arb_state_e             state_q, state_d;
  logic [OW-1:0]          owner_q, owner_d;
  logic [OW-1:0]          last_owner_q, last_owner_d;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_inc_s;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic                   owner_valid_q, owner_valid_d;
  logic [NUM_MASTERS-1:0] req_s, other_req_s;
  logic [OW-1:0]          rr_last_s, winner_s;
  logic                   any_s, idle_s;

  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [OW-1:0] idx);
    logic [NUM_MASTERS-1:0] one;
    one = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

  assign req_s       = ~req;
  assign idle_s      = frame & irdy;
  assign other_req_s = req_s & ~onehot(owner_q);
  assign cnt_inc_s   = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + CW'(1);
  // A BUSY owner is treated as last_owner already, so it only re-wins when alone.
  assign rr_last_s   = (state_q == BUSY) ? owner_q : last_owner_q;

  pci_arb_rr #(
    .NUM_MASTERS(NUM_MASTERS),
    .OW         (OW)
  ) u_rr (
    .req_i       (req_s),
    .last_owner_i(rr_last_s),
    .winner_o    (winner_s),
    .any_o       (any_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= DEAD;
      owner_q       <= '0;
      last_owner_q  <= LAST_RST;
      cnt_q         <= '0;
      gnt_q         <= '1;
      owner_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      cnt_q         <= cnt_d;
      gnt_q         <= gnt_d;
      owner_valid_q <= owner_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = '0;
    case (state_q)
      DEAD: begin
        if (any_s) begin
          state_d = GRANT;
          owner_d = winner_s;
        end else begin
          state_d = PARK;
          owner_d = PARK_IDX;
        end
      end
      PARK: begin
        owner_d = PARK_IDX;
        if (!frame) begin
          state_d = BUSY;
        end else if (any_s) begin
          state_d = (winner_s == PARK_IDX) ? GRANT : DEAD;
        end else begin
          state_d = PARK;
        end
      end
      GRANT: begin
        if (!frame) begin
          state_d = BUSY;
        end else if (idle_s) begin
          cnt_d = cnt_inc_s;
          if (cnt_inc_s == CNT_MAX) begin
            state_d      = DEAD;
            last_owner_d = owner_q;
            cnt_d        = '0;
          end else if (req[owner_q]) begin
            state_d = DEAD;
            cnt_d   = '0;
          end else begin
            state_d = GRANT;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      BUSY: begin
        if (idle_s) begin
          last_owner_d = owner_q;
          if (any_s && (winner_s == owner_q) && !gnt_q[owner_q]) begin
            state_d = GRANT;
          end else begin
            state_d = DEAD;
          end
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d = DEAD;
      end
    endcase
  end

  // Once released during BUSY, gnt stays high until the FSM leaves BUSY.
  always_comb begin
    gnt_d         = '1;
    owner_valid_d = (state_d != DEAD);
    case (state_d)
      PARK, GRANT: gnt_d = ~onehot(owner_d);
      BUSY: begin
        if ((state_q != BUSY) || (!gnt_q[owner_q] && (other_req_s == '0))) begin
          gnt_d = ~onehot(owner_d);
        end else begin
          gnt_d = '1;
        end
      end
      default: gnt_d = '1;
    endcase
  end

  assign gnt         = gnt_q;
  assign owner       = owner_q;
  assign owner_valid = owner_valid_q;

endmodule

// File: tb/tb_pci_arbiter.sv
// Scoreboard bench for pci_arbiter: stimulus queues cycle-tagged expectations,
// a monitor pops and compares them at the falling edge (or on an async probe).
module tb_pci_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       frame;
  logic       irdy;
  logic [1:0] owner;
  logic       owner_valid;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct packed {
    int         cyc;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       ov;
    logic       own_chk;
  } exp_t;

  exp_t  sb[$];
  string nm_q[$];
  event  probe_ev;

  pci_arbiter #(
    .NUM_MASTERS(4),
    .PARK_ID    (0),
    .GNT_TIMEOUT(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .gnt        (gnt),
    .frame      (frame),
    .irdy       (irdy),
    .owner      (owner),
    .owner_valid(owner_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] gnt_of(input int m);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << m);
  endfunction

  task automatic drive(input logic [3:0] r, input logic f, input logic i);
    req   = r;
    frame = f;
    irdy  = i;
  endtask

  task automatic exp_at(input int ofs, input logic [3:0] g, input logic [1:0] o,
                        input logic v, input logic oc, input string nm);
    exp_t e;
    e.cyc     = cyc + ofs;
    e.gnt     = g;
    e.owner   = o;
    e.ov      = v;
    e.own_chk = oc;
    sb.push_back(e);
    nm_q.push_back(nm);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare every expectation whose cycle has come.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk or probe_ev);
      checks++;
      if ($countones(~gnt) > 1) begin
        errors++;
        $display("FAIL onehot cyc=%0d got gnt=%b want at most one low", cyc, gnt);
      end
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e  = sb.pop_front();
        nm = nm_q.pop_front();
        checks++;
        if (e.cyc < cyc) begin
          errors++;
          $display("FAIL %s missed: due cyc=%0d seen cyc=%0d", nm, e.cyc, cyc);
        end else if (gnt !== e.gnt || owner_valid !== e.ov ||
                     (e.own_chk && owner !== e.owner)) begin
          errors++;
          $display("FAIL %s cyc=%0d got gnt=%b owner=%0d valid=%b want gnt=%b owner=%0d valid=%b",
                   nm, cyc, gnt, owner, owner_valid, e.gnt, e.owner, e.ov);
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    drive(4'b1111, 1'b1, 1'b1);
    step(1);
    exp_at(1, 4'b1111, 2'd0, 1'b0, 1'b1, "rst_hold");
    step(1);

    // Release reset: one DEAD cycle, then park on master 0.
    rst = 1'b1;
    exp_at(0, 4'b1111, 2'd0, 1'b0, 1'b1, "dead_after_rst");
    exp_at(1, 4'b1110, 2'd0, 1'b1, 1'b1, "park0");
    step(1);
    exp_at(1, 4'b1110, 2'd0, 1'b1, 1'b1, "park_hold");
    step(1);

    // All request: grants rotate 0,1,2,3,0 with a dead cycle between.
    drive(4'b0000, 1'b1, 1'b1);
    exp_at(1, gnt_of(0), 2'd0, 1'b1, 1'b1, "rr_first");
    step(1);
    for (int k = 0; k < 4; k++) begin
      drive(4'b0000, 1'b0, 1'b1);
      exp_at(1, gnt_of(k), 2'(k), 1'b1, 1'b1, "rr_busy");
      step(1);
      drive(4'b0000, 1'b1, 1'b0);
      exp_at(1, 4'b1111, 2'(k), 1'b1, 1'b1, "rr_gnt_drop");
      step(1);
      drive(4'b0000, 1'b1, 1'b1);
      exp_at(1, 4'b1111, 2'd0, 1'b0, 1'b0, "rr_dead");
      exp_at(2, gnt_of((k + 1) % 4), 2'((k + 1) % 4), 1'b1, 1'b1, "rr_next");
      step(2);
    end
    drive(4'b1111, 1'b1, 1'b1);
    exp_at(1, 4'b1111, 2'd0, 1'b0, 1'b0, "req_drop_dead");
    exp_at(2, 4'b1110, 2'd0, 1'b1, 1'b1, "repark");
    step(2);

    // Parked on 0, master 2 requests.
    drive(4'b1011, 1'b1, 1'b1);
    exp_at(1, 4'b1111, 2'd0, 1'b0, 1'b0, "park_to_dead");
    exp_at(2, 4'b1011, 2'd2, 1'b1, 1'b1, "grant2");
    step(2);
    drive(4'b1111, 1'b0, 1'b1);
    exp_at(1, 4'b1011, 2'd2, 1'b1, 1'b1, "busy2");
    step(1);
    drive(4'b1111, 1'b1, 1'b0);
    exp_at(1, 4'b1011, 2'd2, 1'b1, 1'b1, "busy2_lastdp");
    step(1);
    drive(4'b1111, 1'b1, 1'b1);
    exp_at(1, 4'b1111, 2'd0, 1'b0, 1'b0, "busy2_exit");
    exp_at(2, 4'b1110, 2'd0, 1'b1, 1'b1, "repark2");
    step(2);

    // Master 1 granted, never starts: revoked after 16 idle cycles, 2 next.
    drive(4'b1101, 1'b1, 1'b1);
    exp_at(1, 4'b1111, 2'd0, 1'b0, 1'b0, "to_dead0");
    exp_at(2, 4'b1101, 2'd1, 1'b1, 1'b1, "grant1");
    step(2);
    drive(4'b1001, 1'b1, 1'b1);
    exp_at(15, 4'b1101, 2'd1, 1'b1, 1'b1, "to_hold15");
    exp_at(16, 4'b1111, 2'd0, 1'b0, 1'b0, "timeout_dead");
    exp_at(17, 4'b1011, 2'd2, 1'b1, 1'b1, "grant2_after_to");
    step(17);

    // Master 3 busy, master 0 requests mid-transaction.
    drive(4'b1111, 1'b1, 1'b1);
    exp_at(1, 4'b1111, 2'd0, 1'b0, 1'b0, "g2_release");
    exp_at(2, 4'b1110, 2'd0, 1'b1, 1'b1, "park3");
    step(2);
    drive(4'b0111, 1'b1, 1'b1);
    exp_at(1, 4'b1111, 2'd0, 1'b0, 1'b0, "to_dead3");
    exp_at(2, 4'b0111, 2'd3, 1'b1, 1'b1, "grant3");
    step(2);
    drive(4'b0111, 1'b0, 1'b1);
    exp_at(1, 4'b0111, 2'd3, 1'b1, 1'b1, "busy3");
    step(1);
    drive(4'b0111, 1'b0, 1'b0);
    exp_at(1, 4'b0111, 2'd3, 1'b1, 1'b1, "busy3_hold");
    step(1);
    drive(4'b0110, 1'b0, 1'b0);
    exp_at(1, 4'b1111, 2'd3, 1'b1, 1'b1, "busy3_gnt_drop");
    step(1);
    drive(4'b0110, 1'b1, 1'b0);
    exp_at(1, 4'b1111, 2'd3, 1'b1, 1'b1, "busy3_keeps_bus");
    step(1);
    drive(4'b0110, 1'b1, 1'b1);
    exp_at(1, 4'b1111, 2'd0, 1'b0, 1'b0, "busy3_dead");
    exp_at(2, 4'b1110, 2'd0, 1'b1, 1'b1, "grant0_after3");
    step(2);

    // Sole requester finishing BUSY is re-granted without a gap.
    drive(4'b1110, 1'b0, 1'b1);
    exp_at(1, 4'b1110, 2'd0, 1'b1, 1'b1, "busy0");
    step(1);
    drive(4'b1110, 1'b1, 1'b1);
    exp_at(1, 4'b1110, 2'd0, 1'b1, 1'b1, "busy0_regrant");
    step(1);
    drive(4'b1111, 1'b1, 1'b1);
    exp_at(1, 4'b1111, 2'd0, 1'b0, 1'b0, "g0_release");
    exp_at(2, 4'b1110, 2'd0, 1'b1, 1'b1, "park_b");
    step(2);

    // Frame wins over re-arbitration while parked.
    drive(4'b1011, 1'b0, 1'b1);
    exp_at(1, 4'b1110, 2'd0, 1'b1, 1'b1, "park_busy_prio");
    step(1);

    // Asynchronous reset during BUSY, checked before any further edge.
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    exp_at(0, 4'b1111, 2'd0, 1'b0, 1'b1, "async_rst");
    -> probe_ev;
    drive(4'b1111, 1'b1, 1'b1);
    step(1);
    exp_at(1, 4'b1111, 2'd0, 1'b0, 1'b1, "rst_hold2");
    step(1);
    rst = 1'b1;
    exp_at(0, 4'b1111, 2'd0, 1'b0, 1'b1, "dead_after_rst2");
    exp_at(1, 4'b1110, 2'd0, 1'b1, 1'b1, "park0_again");
    step(1);
    drive(4'b1100, 1'b1, 1'b1);
    exp_at(1, 4'b1110, 2'd0, 1'b1, 1'b1, "rst_rr_master0");
    step(1);

    step(2);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
